uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Frame sequencer for the UART transmit path. Accepts a byte handshake and sequences the 1-byte serializer through its eight data shifts. Inserts the start, optional parity and stop bits, and drives the single TX line. Sits between the register-file/FIFO read side (P_DATA, Data_Valid) and the serializer, and owns the busy flag that both the serializer and upstream logic observe.

## Interface
- STOP_BITS, 1, number of stop bits per frame; legal values are 1 or 2.
- IDLE_LEVEL, 1'b1, TX line level in IDLE and during stop bits.
- CLK  in  1  TX baud-rate clock; one bit per cycle.
- RST  in  1  reset; one clock, reset is asynchronous and active-low.
- P_DATA  in  8  byte to transmit; sampled only on accept.
- Data_Valid  in  1  one-cycle request; accepted only when busy=0.
- PAR_EN  in  1  parity enable; sampled on accept.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled on accept.
- ser_data  in  1  serializer output bit (LSB of its shift register).
- ser_done  in  1  serializer completion flag.
- ser_en  out  1  serializer shift enable.
- busy  out  1  frame in progress; also feeds the serializer's Basy_signal input.
- TX_OUT  out  1  serial line.
- seq_err  out  1  sticky flag: serializer completion misaligned with the frame.

## Operation
- States:
  - IDLE: TX_OUT=IDLE_LEVEL, busy=0, ser_en=0.
  - START: TX_OUT=0.
  - DATA: TX_OUT=ser_data, ser_en=1.
  - PARITY: TX_OUT=par_bit.
  - STOP: TX_OUT=IDLE_LEVEL.
- Accept: Data_Valid=1 in IDLE.
  - On that edge the serializer loads P_DATA, because busy=0 on the same edge.
  - The controller goes to START and latches par_en_q, par_bit, and a cleared 3-bit bit_cnt.
  - par_bit = ^P_DATA for even parity, ~^P_DATA for odd parity.
- START to DATA after 1 cycle.
- DATA: lasts exactly 8 cycles; bit_cnt increments each cycle.
  - At bit_cnt==7, go to PARITY if par_en_q, otherwise to STOP.
  - ser_en is high for all 8 DATA cycles, so data goes out LSB first.
- PARITY to STOP after 1 cycle.
- STOP: lasts STOP_BITS cycles, counted with stop_cnt, then returns to IDLE.
- Data_Valid outside IDLE is ignored. Nothing is queued, and the serializer also ignores it because busy=1.
- seq_err check:
  - In the first cycle after DATA (PARITY or first STOP), ser_done must be 1.
  - In every DATA cycle except the first, ser_done must be 0.
  - Any violation sets seq_err, which is held until reset.
- bit_cnt wraps 7 to 0 naturally; the state exit takes precedence over the wrap.

## Timing
- Reset values: TX_OUT=IDLE_LEVEL, busy=0, ser_en=0, seq_err=0, state=IDLE, all counters 0.
- All outputs are registered state decodes; TX_OUT has no combinational path from Data_Valid.
- TX_OUT in DATA is ser_data, which passes through combinationally from the serializer register.
- Accept edge is T0:
  - T0 to T0+1: START, busy=1.
  - T0+1 to T0+9: DATA.
  - Then PARITY (if enabled), then STOP.
- Frame length is 1 + 8 + par_en_q + STOP_BITS cycles: 10 to 12.
- Earliest next accept is the first IDLE cycle after the frame. The minimum gap is 0 idle cycles beyond the Data_Valid cycle itself.
- Reset asserted mid-frame: immediate return to IDLE and TX_OUT=IDLE_LEVEL. Any partial frame is abandoned; no completion of the stop bit.
- Data_Valid and reset deassertion in the same cycle: no accept on that edge.

## Structure
- Shared package uart_tx_pkg:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP).
  - STOP_BITS legal-range constants.
  - start level constant START_LVL=0.
- One natural sub-module: uart_tx_parity, a combinational parity of 8 bits selected by PAR_TYP. The latch stays in the controller.
- The output mux (start/data/parity/stop) stays inline in the controller.
- Parameter check: STOP_BITS other than 1 or 2 is an elaboration error.

## Test plan
- Byte 0xA5, PAR_EN=0, STOP_BITS=1 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles); busy high for exactly 10 cycles; seq_err=0.
- Byte 0x07, PAR_EN=1, PAR_TYP=0 -> parity bit 1; with PAR_TYP=1 -> parity bit 0; frame is 11 cycles, parity bit in cycle 10.
- STOP_BITS=2, byte 0xFF, even parity -> parity 0, followed by two cycles of 1, then IDLE; 12-cycle frame.
- Data_Valid pulsed at DATA cycle 3 with byte 0x3C during a 0x55 frame -> ignored; 0x55 is transmitted intact; the next accept happens only in IDLE.
- RST pulled low in DATA cycle 4 -> TX_OUT=1, busy=0 asynchronously; after release, a new 0x81 frame transmits correctly.
- ser_done forced to 0 after the DATA phase -> seq_err=1, remains 1 through later frames until reset.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for the UART transmit frame sequencer.
// Holds the frame state encoding, stop-bit range limits and line-level constants.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int   DATA_BITS     = 8;
    localparam int   STOP_BITS_MIN = 1;
    localparam int   STOP_BITS_MAX = 2;
    localparam logic START_LVL     = 1'b0;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: byte handshake between the upstream FIFO/register side and the TX sequencer.
// master drives P_DATA, Data_Valid, PAR_EN, PAR_TYP; slave (the sequencer) drives busy.
interface uart_tx_ctrl_if
    import uart_tx_pkg::*;
;
    logic [DATA_BITS-1:0] P_DATA;
    logic                 Data_Valid;
    logic                 PAR_EN;
    logic                 PAR_TYP;
    logic                 busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        input  busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        output busy
    );

endinterface

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: combinational parity of one data byte.
// Ports: data (byte), par_typ (0 even / 1 odd), par_bit (parity bit to transmit).
module uart_tx_parity
    import uart_tx_pkg::*;
(
    input  logic [DATA_BITS-1:0] data,
    input  logic                 par_typ,
    output logic                 par_bit
);

    assign par_bit = par_typ ? ~^data : ^data;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART TX frame sequencer (start, 8 serializer data bits, parity, stop).
// Ports: CLK/RST (async active-low), up (byte handshake, slave), ser_data/ser_done
// from the serializer, ser_en to it, TX_OUT serial line, seq_err sticky alignment error.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int   STOP_BITS  = 1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  up,
    input  logic           ser_data,
    input  logic           ser_done,
    output logic           ser_en,
    output logic           TX_OUT,
    output logic           seq_err
);

    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
        $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end

    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t  state;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
    logic       par_en_q;
    logic       par_bit_q;
    logic       first_post;
    logic       busy_q;
    logic       ser_en_q;
    logic       seq_err_q;
    logic       par_bit;

    uart_tx_parity u_par (
        .data    (up.P_DATA),
        .par_typ (up.PAR_TYP),
        .par_bit (par_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            first_post <= 1'b0;
            busy_q     <= 1'b0;
            ser_en_q   <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            first_post <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (up.Data_Valid) begin
                        state     <= ST_START;
                        busy_q    <= 1'b1;
                        par_en_q  <= up.PAR_EN;
                        par_bit_q <= par_bit;
                        bit_cnt   <= '0;
                    end
                end
                ST_START: begin
                    state    <= ST_DATA;
                    ser_en_q <= 1'b1;
                end
                ST_DATA: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    // serializer must not finish before its eighth shift
                    if (bit_cnt != 3'd0 && ser_done) begin
                        seq_err_q <= 1'b1;
                    end
                    if (bit_cnt == 3'd7) begin
                        ser_en_q   <= 1'b0;
                        first_post <= 1'b1;
                        stop_cnt   <= 1'b0;
                        state      <= par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    state <= ST_STOP;
                end
                ST_STOP: begin
                    if (stop_cnt == LAST_STOP) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // serializer must report done right after the data phase
            if (first_post && !ser_done) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        TX_OUT = IDLE_LEVEL;
        unique case (state)
            ST_START:  TX_OUT = START_LVL;
            ST_DATA:   TX_OUT = ser_data;
            ST_PARITY: TX_OUT = par_bit_q;
            default:   TX_OUT = IDLE_LEVEL;
        endcase
    end

    assign up.busy = busy_q;
    assign ser_en  = ser_en_q;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: bench for uart_tx_ctrl with one and two stop bits side by side.
// Frame-level model plus serializer model; directed frames with literal expectations.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] pdata = 8'h00;
    logic       dv = 1'b0;
    logic       pen = 1'b0;
    logic       ptyp = 1'b0;
    logic       force_low = 1'b0;

    always #5 CLK = ~CLK;

    uart_tx_ctrl_if ifa ();
    uart_tx_ctrl_if ifb ();

    assign ifa.P_DATA     = pdata;
    assign ifa.Data_Valid = dv;
    assign ifa.PAR_EN     = pen;
    assign ifa.PAR_TYP    = ptyp;
    assign ifb.P_DATA     = pdata;
    assign ifb.Data_Valid = dv;
    assign ifb.PAR_EN     = pen;
    assign ifb.PAR_TYP    = ptyp;

    logic sd    [2];
    logic sdone [2];
    logic sen   [2];
    logic tx    [2];
    logic err   [2];
    logic busyv [2];

    assign busyv[0] = ifa.busy;
    assign busyv[1] = ifb.busy;

    uart_tx_ctrl #(.STOP_BITS(1), .IDLE_LEVEL(1'b1)) u_dut1 (
        .CLK      (CLK),
        .RST      (RST),
        .up       (ifa.slave),
        .ser_data (sd[0]),
        .ser_done (sdone[0]),
        .ser_en   (sen[0]),
        .TX_OUT   (tx[0]),
        .seq_err  (err[0])
    );

    uart_tx_ctrl #(.STOP_BITS(2), .IDLE_LEVEL(1'b1)) u_dut2 (
        .CLK      (CLK),
        .RST      (RST),
        .up       (ifb.slave),
        .ser_data (sd[1]),
        .ser_done (sdone[1]),
        .ser_en   (sen[1]),
        .TX_OUT   (tx[1]),
        .seq_err  (err[1])
    );

    // serializer: loads when not busy, shifts right on ser_en, done after 8 shifts
    logic [7:0] sh   [2];
    int         scnt [2];

    always @(posedge CLK or negedge RST) begin
        for (int k = 0; k < 2; k++) begin
            if (!RST) begin
                sh[k]   <= 8'h00;
                scnt[k] <= 0;
            end else if (dv && !busyv[k]) begin
                sh[k]   <= pdata;
                scnt[k] <= 0;
            end else if (sen[k]) begin
                sh[k]   <= sh[k] >> 1;
                scnt[k] <= scnt[k] + 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            sd[k]    = sh[k][0];
            sdone[k] = (scnt[k] == 8) && !force_low;
        end
    end

    // frame model: expected line bits indexed by position within the frame
    int          vectors = 0;
    int          miscompares = 0;
    int          pos   [2] = '{-1, -1};
    logic [11:0] fb    [2];
    int          flen  [2] = '{0, 0};
    logic        merr  [2] = '{1'b0, 1'b0};
    int          nstop [2] = '{1, 2};

    always @(posedge CLK or negedge RST) begin
        for (int k = 0; k < 2; k++) begin
            if (!RST) begin
                pos[k]  = -1;
                merr[k] = 1'b0;
            end else if (pos[k] < 0) begin
                if (dv) begin
                    fb[k]    = '1;
                    fb[k][0] = 1'b0;
                    for (int i = 0; i < 8; i++) fb[k][1+i] = pdata[i];
                    flen[k] = 9 + nstop[k];
                    if (pen) begin
                        fb[k][9] = (($countones(pdata) % 2) == 1) ^ ptyp;
                        flen[k]  = 10 + nstop[k];
                    end
                    pos[k] = 0;
                end
            end else begin
                if (pos[k] >= 2 && pos[k] <= 8 && sdone[k]) merr[k] = 1'b1;
                if (pos[k] == 9 && !sdone[k]) merr[k] = 1'b1;
                pos[k] = pos[k] + 1;
                if (pos[k] == flen[k]) pos[k] = -1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            for (int k = 0; k < 2; k++) begin
                logic et;
                et = (pos[k] < 0) ? 1'b1 : fb[k][pos[k]];
                check($sformatf("tx%0d", k), 32'(tx[k]), 32'(et));
                check($sformatf("busy%0d", k), 32'(busyv[k]), 32'(pos[k] >= 0));
                check($sformatf("ser_en%0d", k), 32'(sen[k]),
                      32'(pos[k] >= 1 && pos[k] <= 8));
                check($sformatf("seq_err%0d", k), 32'(err[k]), 32'(merr[k]));
            end
        end
    end

    logic cap0 [13];
    logic cap1 [13];
    int   bc0;
    int   bc1;

    task automatic frame(input logic [7:0] b, input logic pe, input logic pt,
                         input int inj_dv, input int inj_rst);
        bit did_rst;
        did_rst = 1'b0;
        @(posedge CLK); #2;
        pdata = b; pen = pe; ptyp = pt; dv = 1'b1;
        @(posedge CLK); #2;
        dv = 1'b0;
        bc0 = 0;
        bc1 = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            cap0[i] = tx[0];
            cap1[i] = tx[1];
            bc0 += int'(busyv[0]);
            bc1 += int'(busyv[1]);
            if (i == inj_dv) begin
                #1 pdata = 8'h3C; dv = 1'b1;
            end
            if (i == inj_dv + 1) begin
                #1 dv = 1'b0;
            end
            if (i == inj_rst) begin
                #1 RST = 1'b0;
                #1;
                check("rst_tx0", 32'(tx[0]), 32'd1);
                check("rst_tx1", 32'(tx[1]), 32'd1);
                check("rst_busy0", 32'(busyv[0]), 32'd0);
                check("rst_busy1", 32'(busyv[1]), 32'd0);
                did_rst = 1'b1;
                break;
            end
        end
        if (did_rst) begin
            @(posedge CLK); #2;
            RST = 1'b1;
        end
    endtask

    function automatic logic [31:0] seq0(input int n);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s = {s[30:0], cap0[i]};
        return s;
    endfunction

    function automatic logic [31:0] seq1(input int n);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s = {s[30:0], cap1[i]};
        return s;
    endfunction

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("reset_tx0", 32'(tx[0]), 32'd1);
        check("reset_busy0", 32'(busyv[0]), 32'd0);
        check("reset_ser_en0", 32'(sen[0]), 32'd0);
        check("reset_seq_err0", 32'(err[0]), 32'd0);
        check("reset_tx1", 32'(tx[1]), 32'd1);
        check("reset_busy1", 32'(busyv[1]), 32'd0);
        #1 RST = 1'b1;

        frame(8'hA5, 1'b0, 1'b0, -5, -1);
        check("a5_seq", seq0(10), 32'b0101001011);
        check("a5_busy", 32'(bc0), 32'd10);
        check("a5_idle_after", 32'(cap0[10]), 32'd1);
        check("a5_seq_2stop", seq1(11), 32'b01010010111);
        check("a5_busy_2stop", 32'(bc1), 32'd11);
        check("a5_err", 32'(err[0]), 32'd0);

        frame(8'h07, 1'b1, 1'b0, -5, -1);
        check("07_even_seq", seq0(11), 32'b01110000011);
        check("07_even_par", 32'(cap0[9]), 32'd1);
        check("07_even_busy", 32'(bc0), 32'd11);

        frame(8'h07, 1'b1, 1'b1, -5, -1);
        check("07_odd_par", 32'(cap0[9]), 32'd0);
        check("07_odd_busy", 32'(bc0), 32'd11);

        frame(8'hFF, 1'b1, 1'b0, -5, -1);
        check("ff_2stop_seq", seq1(12), 32'b011111111011);
        check("ff_2stop_busy", 32'(bc1), 32'd12);
        check("ff_2stop_idle", 32'(cap1[12]), 32'd1);

        frame(8'h55, 1'b0, 1'b0, 3, -1);
        check("55_inj_seq", seq0(10), 32'b0101010101);
        check("55_inj_busy", 32'(bc0), 32'd10);
        check("55_inj_busy_2stop", 32'(bc1), 32'd11);

        frame(8'h99, 1'b0, 1'b0, -5, 4);
        frame(8'h81, 1'b0, 1'b0, -5, -1);
        check("81_seq", seq0(10), 32'b0100000011);
        check("81_busy", 32'(bc0), 32'd10);

        force_low = 1'b1;
        frame(8'h5A, 1'b0, 1'b0, -5, -1);
        force_low = 1'b0;
        check("fault_err0", 32'(err[0]), 32'd1);
        check("fault_err1", 32'(err[1]), 32'd1);
        frame(8'h12, 1'b1, 1'b0, -5, -1);
        check("fault_sticky0", 32'(err[0]), 32'd1);
        check("fault_sticky1", 32'(err[1]), 32'd1);

        @(posedge CLK); #2;
        RST = 1'b0;
        #1;
        check("err_clear0", 32'(err[0]), 32'd0);
        check("err_clear1", 32'(err[1]), 32'd0);
        @(posedge CLK); #2;
        RST = 1'b1;

        frame(8'h3C, 1'b1, 1'b1, -5, -1);
        check("3c_odd_par", 32'(cap0[9]), 32'd1);
        check("3c_err", 32'(err[0]), 32'd0);

        repeat (2) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
